sequenciador_rodada: RTL and testbench

//  Round controller for the memory game. Builds a growing sequence of one-hot colour codes

---
 rtl/sequenciador_pkg.sv | 38 +++
 rtl/temporizador_jogo.sv | 41 ++++
 rtl/sequenciador_rodada.sv | 230 +++++++++++++++++++++++
 tb/tb_sequenciador_rodada.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_pkg.sv
// ---------------------------------------------------------------------------
// sequenciador_pkg
// Shared definitions for the memory-game round controller:
//   - FSM state codes (kept as plain localparams so older tools and
//     waveform viewers that decode raw vectors still work);
//   - seed_para_cor : maps the 2-bit free-running seed to a one-hot colour;
//   - eh_one_hot    : tells whether a player entry names exactly one colour.
// ---------------------------------------------------------------------------
package sequenciador_pkg;

  localparam int ESTADO_W = 3;

  localparam logic [ESTADO_W-1:0] OCIOSO     = 3'd0;
  localparam logic [ESTADO_W-1:0] GERA       = 3'd1;
  localparam logic [ESTADO_W-1:0] MOSTRA_ON  = 3'd2;
  localparam logic [ESTADO_W-1:0] MOSTRA_OFF = 3'd3;
  localparam logic [ESTADO_W-1:0] ESPERA     = 3'd4;
  localparam logic [ESTADO_W-1:0] FIM_ACERTO = 3'd5;
  localparam logic [ESTADO_W-1:0] FIM_ERRO   = 3'd6;

  // Seed 00 is the leftmost colour; higher seeds move the lit bit right.
  function automatic logic [3:0] seed_para_cor(input logic [1:0] seed);
    logic [3:0] cor;
    case (seed)
      2'b00:   cor = 4'b1000;
      2'b01:   cor = 4'b0100;
      2'b10:   cor = 4'b0010;
      default: cor = 4'b0001;
    endcase
    return cor;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic eh_one_hot(input logic [3:0] valor);
    return (valor != 4'b0000) && ((valor & (valor - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/temporizador_jogo.sv
// ---------------------------------------------------------------------------
// temporizador_jogo
// Loadable down-counter used for every timed interval of the round
// controller (LED on time, LED off time and, when built, player timeout).
// Loading N makes 'terminou' rise after N further enabled cycles, so an
// interval of T cycles is obtained by loading T-1 on entry.
// Ports:
//   clock      in  1  system clock
//   zera_s_n   in  1  synchronous reset, active low (count -> 0)
//   carregar   in  1  load 'valor' this cycle (wins over counting)
//   habilitar  in  1  count down while non-zero
//   valor      in  W  value to load
//   terminou   out 1  count has reached zero
// ---------------------------------------------------------------------------
module temporizador_jogo #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         zera_s_n,
  input  logic         carregar,
  input  logic         habilitar,
  input  logic [W-1:0] valor,
  output logic         terminou
);

  logic [W-1:0] contagem;

  // Counting saturates at zero so 'terminou' stays high until the next load.
  always_ff @(posedge clock) begin
    if (!zera_s_n) begin
      contagem <= '0;
    end else if (carregar) begin
      contagem <= valor;
    end else if (habilitar && (contagem != '0)) begin
      contagem <= contagem - W'(1);
    end
  end

  assign terminou = (contagem == '0);

endmodule

// File: rtl/sequenciador_rodada.sv
// ---------------------------------------------------------------------------
// sequenciador_rodada
// Round controller for the memory game. Each round appends one colour
// (derived from a free-running 2-bit seed) to the stored sequence, plays
// the whole sequence on 'leds' and then checks the player's entries in
// order. Sits between the input debouncer and the LED/display drivers.
//
// Parameters:
//   MAX_LEN   sequence length that wins the game
//   LEN_W     width of rodada/idx; must hold MAX_LEN
//   T_ON      cycles each colour is lit during playback
//   T_OFF     dark cycles after each colour
//   T_TIMEOUT player inactivity limit (only with SEQ_TIMEOUT_EN)
//
// Ports:
//   clock         in  1      system clock, posedge
//   zera_s_n      in  1      synchronous reset, active low
//   iniciar       in  1      start / restart request (level)
//   jogada        in  4      player colour, one-hot
//   jogada_valida in  1      one-cycle strobe qualifying jogada
//   leds          out 4      colour shown during playback, else 0
//   vez_jogador   out 1      high while waiting for player entries
//   rodada        out LEN_W  current sequence length
//   acertou       out 1      one-cycle pulse per correct entry
//   ganhou        out 1      game won (level)
//   errou         out 1      game lost (level)
//
// Build option:
//   SEQ_TIMEOUT_EN  when defined, T_TIMEOUT idle cycles in ESPERA lose the
//                   game; each valid entry restarts the wait. Without it
//                   ESPERA waits forever and the timeout path is not built.
// ---------------------------------------------------------------------------
module sequenciador_rodada
  import sequenciador_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = 5,
  parameter int T_ON      = 500,
  parameter int T_OFF     = 250,
  parameter int T_TIMEOUT = 5000
) (
  input  logic             clock,
  input  logic             zera_s_n,
  input  logic             iniciar,
  input  logic [3:0]       jogada,
  input  logic             jogada_valida,
  output logic [3:0]       leds,
  output logic             vez_jogador,
  output logic [LEN_W-1:0] rodada,
  output logic             acertou,
  output logic             ganhou,
  output logic             errou
);

  // The shared timer only needs to hold the longest interval it is loaded with.
  localparam int T_MAX_LED = (T_ON > T_OFF) ? T_ON : T_OFF;
`ifdef SEQ_TIMEOUT_EN
  localparam int T_MAX = (T_MAX_LED > T_TIMEOUT) ? T_MAX_LED : T_TIMEOUT;
`else
  localparam int T_MAX = T_MAX_LED;
`endif
  localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  // Reject configurations whose counters cannot represent the game.
  if (MAX_LEN < 2 || MAX_LEN >= (1 << LEN_W) ||
      T_ON < 1 || T_OFF < 1 || T_TIMEOUT < 1) begin : g_parametros_invalidos
    $error("sequenciador_rodada: invalid parameter combination");
  end

  logic [ESTADO_W-1:0] estado;
  logic [ESTADO_W-1:0] proximo;
  logic [LEN_W-1:0]    idx;
  logic [LEN_W-1:0]    idx_prox;
  logic [LEN_W-1:0]    rodada_prox;
  logic [1:0]          seed;
  logic [3:0]          seq [MAX_LEN];
  logic [3:0]          cor_atual;
  logic                acertou_prox;
  logic                gravar;
  logic                ultimo;
  logic                recarregar;
  logic                carregar;
  logic                habilitar;
  logic [TIMER_W-1:0]  valor;
  logic                terminou;

  // Read port of the sequence store; a compare loop keeps the index width
  // independent of the array depth.
  always_comb begin
    cor_atual = 4'b0000;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == LEN_W'(i)) begin
        cor_atual = seq[i];
      end
    end
  end

  // Next-state and datapath control. Playback and checking both walk idx
  // from 0 up to rodada-1; 'ultimo' marks the final position of the round.
  always_comb begin
    proximo      = estado;
    idx_prox     = idx;
    rodada_prox  = rodada;
    acertou_prox = 1'b0;
    gravar       = 1'b0;
    recarregar   = 1'b0;
    ultimo       = (idx == rodada - LEN_W'(1));
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          proximo = GERA;
        end
      end
      GERA: begin
        gravar      = 1'b1;
        rodada_prox = rodada + LEN_W'(1);
        idx_prox    = '0;
        proximo     = MOSTRA_ON;
      end
      MOSTRA_ON: begin
        if (terminou) begin
          proximo = MOSTRA_OFF;
        end
      end
      MOSTRA_OFF: begin
        if (terminou) begin
          if (ultimo) begin
            idx_prox = '0;
            proximo  = ESPERA;
          end else begin
            idx_prox = idx + LEN_W'(1);
            proximo  = MOSTRA_ON;
          end
        end
      end
      ESPERA: begin
        if (jogada_valida) begin
          if (eh_one_hot(jogada) && (jogada == cor_atual)) begin
            acertou_prox = 1'b1;
            if (ultimo) begin
              proximo = (rodada == LEN_W'(MAX_LEN)) ? FIM_ACERTO : GERA;
            end else begin
              idx_prox   = idx + LEN_W'(1);
              recarregar = 1'b1;
            end
          end else begin
            proximo = FIM_ERRO;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (terminou) begin
          proximo = FIM_ERRO;
        end
`endif
      end
      FIM_ACERTO, FIM_ERRO: begin
        if (iniciar) begin
          rodada_prox = '0;
          proximo     = GERA;
        end
      end
      default: begin
        proximo = OCIOSO;
      end
    endcase
  end

  // Timer is reloaded on every state entry with the length of the new
  // interval, and again after each accepted entry so the timeout restarts.
  always_comb begin
    valor = '0;
    case (proximo)
      MOSTRA_ON:  valor = TIMER_W'(T_ON - 1);
      MOSTRA_OFF: valor = TIMER_W'(T_OFF - 1);
`ifdef SEQ_TIMEOUT_EN
      ESPERA:     valor = TIMER_W'(T_TIMEOUT - 1);
`endif
      default:    valor = '0;
    endcase
  end

  assign carregar  = (proximo != estado) || recarregar;
  assign habilitar = (estado == MOSTRA_ON) || (estado == MOSTRA_OFF) ||
                     (estado == ESPERA);

  temporizador_jogo #(
    .W (TIMER_W)
  ) u_temporizador (
    .clock     (clock),
    .zera_s_n  (zera_s_n),
    .carregar  (carregar),
    .habilitar (habilitar),
    .valor     (valor),
    .terminou  (terminou)
  );

  // Control registers; reset overrides everything, including playback.
  always_ff @(posedge clock) begin
    if (!zera_s_n) begin
      estado  <= OCIOSO;
      idx     <= '0;
      rodada  <= '0;
      seed    <= 2'b00;
      acertou <= 1'b0;
    end else begin
      estado  <= proximo;
      idx     <= idx_prox;
      rodada  <= rodada_prox;
      seed    <= seed + 2'b01;
      acertou <= acertou_prox;
    end
  end

  // Sequence store: no reset, entries beyond rodada are never read.
  always_ff @(posedge clock) begin
    if (zera_s_n && gravar) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (rodada == LEN_W'(i)) begin
          seq[i] <= seed_para_cor(seed);
        end
      end
    end
  end

  assign leds        = (estado == MOSTRA_ON) ? cor_atual : 4'b0000;
  assign vez_jogador = (estado == ESPERA);
  assign ganhou      = (estado == FIM_ACERTO);
  assign errou       = (estado == FIM_ERRO);

endmodule

// File: tb/tb_sequenciador_rodada.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_rodada
// Drives the round controller with directed game scenarios followed by a
// long randomized run. A behavioural game model (sequence queue plus a
// queue of the LED values still to be shown) predicts every output each
// cycle; a few hand-computed values pin the model itself.
// Honours SEQ_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_sequenciador_rodada;

  localparam int MAX_LEN   = 3;
  localparam int LEN_W     = 2;
  localparam int T_ON      = 2;
  localparam int T_OFF     = 1;
  localparam int T_TIMEOUT = 6;

  localparam int P_IDLE = 0;
  localparam int P_GEN  = 1;
  localparam int P_PLAY = 2;
  localparam int P_WAIT = 3;
  localparam int P_WON  = 4;
  localparam int P_LOST = 5;

  logic             clock = 1'b0;
  logic             zera_s_n;
  logic             iniciar;
  logic [3:0]       jogada;
  logic             jogada_valida;
  logic [3:0]       leds;
  logic             vez_jogador;
  logic [LEN_W-1:0] rodada;
  logic             acertou;
  logic             ganhou;
  logic             errou;

  always #5 clock = ~clock;

  sequenciador_rodada #(
    .MAX_LEN   (MAX_LEN),
    .LEN_W     (LEN_W),
    .T_ON      (T_ON),
    .T_OFF     (T_OFF),
    .T_TIMEOUT (T_TIMEOUT)
  ) dut (
    .clock         (clock),
    .zera_s_n      (zera_s_n),
    .iniciar       (iniciar),
    .jogada        (jogada),
    .jogada_valida (jogada_valida),
    .leds          (leds),
    .vez_jogador   (vez_jogador),
    .rodada        (rodada),
    .acertou       (acertou),
    .ganhou        (ganhou),
    .errou         (errou)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;
  int total_acertou = 0;
  bit pend          = 1'b0;

  int         m_phase = P_IDLE;
  int         m_n     = 0;
  int         m_idx   = 0;
  int         m_idle  = 0;
  bit         m_acert = 1'b0;
  logic [3:0] m_seq [$];
  logic [3:0] m_play [$];

  logic [3:0]       exp_leds    = 4'b0;
  logic             exp_vez     = 1'b0;
  logic [LEN_W-1:0] exp_rodada  = '0;
  logic             exp_acertou = 1'b0;
  logic             exp_ganhou  = 1'b0;
  logic             exp_errou   = 1'b0;

  function automatic logic [3:0] colour_of(input int s);
    logic [3:0] top;
    top = 4'b1000;
    return top >> s;
  endfunction

  // One clock of the game as the player sees it.
  task automatic model_step(input logic rst_n, input logic ini,
                            input logic [3:0] jog, input logic val);
    int seed_now;
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_n     = 0;
      m_idx   = 0;
      m_idle  = 0;
      m_acert = 1'b0;
      m_seq.delete();
      m_play.delete();
    end else begin
      seed_now = m_n % 4;
      m_n++;
      m_acert = 1'b0;
      case (m_phase)
        P_IDLE: if (ini) m_phase = P_GEN;
        P_GEN: begin
          m_seq.push_back(colour_of(seed_now));
          m_play.delete();
          foreach (m_seq[k]) begin
            repeat (T_ON) m_play.push_back(m_seq[k]);
            repeat (T_OFF) m_play.push_back(4'b0000);
          end
          m_phase = P_PLAY;
        end
        P_PLAY: begin
          void'(m_play.pop_front());
          if (m_play.size() == 0) begin
            m_phase = P_WAIT;
            m_idx   = 0;
            m_idle  = 0;
          end
        end
        P_WAIT: begin
          if (val) begin
            if (jog == m_seq[m_idx]) begin
              m_acert = 1'b1;
              m_idle  = 0;
              if (m_idx == m_seq.size() - 1)
                m_phase = (m_seq.size() == MAX_LEN) ? P_WON : P_GEN;
              else
                m_idx++;
            end else begin
              m_phase = P_LOST;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else begin
            m_idle++;
            if (m_idle == T_TIMEOUT) m_phase = P_LOST;
          end
`endif
        end
        P_WON, P_LOST: begin
          if (ini) begin
            m_seq.delete();
            m_phase = P_GEN;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    exp_leds    = (m_phase == P_PLAY) ? m_play[0] : 4'b0000;
    exp_vez     = (m_phase == P_WAIT);
    exp_rodada  = LEN_W'(m_seq.size());
    exp_acertou = m_acert;
    exp_ganhou  = (m_phase == P_WON);
    exp_errou   = (m_phase == P_LOST);
  endtask

  task automatic compare(input string name, input logic [7:0] act,
                         input logic [7:0] req);
    if (act !== req) begin
      n_miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput();
    n_vectors++;
    compare("leds",        8'(leds),        8'(exp_leds));
    compare("vez_jogador", 8'(vez_jogador), 8'(exp_vez));
    compare("rodada",      8'(rodada),      8'(exp_rodada));
    compare("acertou",     8'(acertou),     8'(exp_acertou));
    compare("ganhou",      8'(ganhou),      8'(exp_ganhou));
    compare("errou",       8'(errou),       8'(exp_errou));
  endtask

  // Single compare process: checks the DUT after each stimulated edge.
  always @(posedge clock) begin
    #1;
    if (pend) begin
      pend = 1'b0;
      checkOutput();
    end
  end

  task automatic applyStimulus(input logic rst_n, input logic ini,
                               input logic [3:0] jog, input logic val);
    @(negedge clock);
    zera_s_n      = rst_n;
    iniciar       = ini;
    jogada        = jog;
    jogada_valida = val;
    model_step(rst_n, ini, jog, val);
    pend = 1'b1;
    @(posedge clock);
    #2;
    if (acertou === 1'b1) total_acertou++;
  endtask

  // Idle (or noisy, to show strobes are ignored) until the player's turn.
  task automatic wait_turn(input bit noise);
    for (int c = 0; c < 100 && m_phase != P_WAIT; c++)
      applyStimulus(1'b1, 1'b0, 4'($urandom_range(0, 15)), noise);
    compare("wait_turn", 8'(vez_jogador), 8'd1);
  endtask

  task automatic play_round();
    int n;
    wait_turn(1'b0);
    n = m_seq.size();
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'b0, m_seq[m_idx], 1'b1);
  endtask

  initial begin
    logic [3:0] wrong;
    logic       r_rst;
    logic       r_ini;
    logic       r_val;
    logic [3:0] r_jog;
    zera_s_n      = 1'b0;
    iniciar       = 1'b0;
    jogada        = 4'b0;
    jogada_valida = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 4'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0, 1'b0);
    compare("reset_leds",    8'(leds),        8'd0);
    compare("reset_vez",     8'(vez_jogador), 8'd0);
    compare("reset_rodada",  8'(rodada),      8'd0);
    compare("reset_acertou", 8'(acertou),     8'd0);
    compare("reset_ganhou",  8'(ganhou),      8'd0);
    compare("reset_errou",   8'(errou),       8'd0);

    $display("[TB] first round playback");
    applyStimulus(1'b1, 1'b1, 4'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0);
    compare("first_colour",       8'(leds),     8'h04);
    compare("model_first_colour", 8'(exp_leds), 8'h04);
    compare("first_rodada",       8'(rodada),   8'd1);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0);
    compare("first_colour_hold",  8'(leds),     8'h04);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0);
    compare("first_dark",         8'(leds),     8'h00);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0);
    compare("first_turn",         8'(vez_jogador), 8'd1);

    $display("[TB] full game win");
    total_acertou = 0;
    for (int r = 0; r < MAX_LEN; r++) play_round();
    compare("win_pulses", 8'(total_acertou), 8'd6);
    compare("win_ganhou", 8'(ganhou),        8'd1);
    compare("win_rodada", 8'(rodada),        8'd3);

    $display("[TB] wrong colour in round 2");
    applyStimulus(1'b1, 1'b1, 4'b0, 1'b0);
    compare("restart_ganhou", 8'(ganhou), 8'd0);
    play_round();
    wait_turn(1'b0);
    applyStimulus(1'b1, 1'b0, m_seq[0], 1'b1);
    wrong = {m_seq[1][0], m_seq[1][3:1]};
    applyStimulus(1'b1, 1'b0, wrong, 1'b1);
    compare("wrong_errou", 8'(errou),       8'd1);
    compare("wrong_vez",   8'(vez_jogador), 8'd0);
    applyStimulus(1'b1, 1'b1, 4'b0, 1'b0);
    compare("retry_errou", 8'(errou), 8'd0);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0);
    compare("retry_rodada", 8'(rodada), 8'd1);

    $display("[TB] strobes during playback, non-one-hot entry");
    wait_turn(1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0110, 1'b1);
    compare("multi_hot_errou", 8'(errou), 8'd1);

    $display("[TB] reset during playback");
    applyStimulus(1'b1, 1'b1, 4'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0, 1'b0);
    compare("midreset_leds",   8'(leds),        8'd0);
    compare("midreset_rodada", 8'(rodada),      8'd0);
    compare("midreset_vez",    8'(vez_jogador), 8'd0);

`ifdef SEQ_TIMEOUT_EN
    $display("[TB] player timeout");
    applyStimulus(1'b1, 1'b1, 4'b0, 1'b0);
    wait_turn(1'b0);
    repeat (T_TIMEOUT - 1) applyStimulus(1'b1, 1'b0, 4'b0, 1'b0);
    compare("timeout_not_yet", 8'(errou), 8'd0);
    applyStimulus(1'b1, 1'b0, 4'b0, 1'b0);
    compare("timeout_errou", 8'(errou), 8'd1);
`endif

    $display("[TB] randomized play");
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 199) != 0);
      r_ini = ($urandom_range(0, 5) == 0);
      r_val = ($urandom_range(0, 2) == 0);
      if (m_phase == P_WAIT && $urandom_range(0, 4) != 0)
        r_jog = m_seq[m_idx];
      else if ($urandom_range(0, 1) == 1)
        r_jog = colour_of($urandom_range(0, 3));
      else
        r_jog = 4'($urandom_range(0, 15));
      applyStimulus(r_rst, r_ini, r_jog, r_val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
